// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter driving the io_tx line.
// Ports: clk, reset_n (sync, active-low), tx_data/tx_valid/tx_ready
// push handshake, io_tx serial out (idle high, registered), busy,
// fifo_count (bytes queued, excluding the byte in the shifter).
module uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              io_tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              io_tx_q, io_tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push    = tx_valid && !full;
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so io_tx changes on the same
  // edge as the state transition while still coming from a flop.
  always_comb begin
    io_tx_d = 1'b1;
    unique case (state_d)
      START:   io_tx_d = 1'b0;
      DATA:    io_tx_d = shift_d[0];
      default: io_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      io_tx_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      io_tx_q <= io_tx_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx_ready   = !full;
  assign io_tx      = io_tx_q;
  assign busy       = !empty || (state_q != IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx, 10 clocks per bit, depth 4.
// Checks line levels cycle by cycle against a frame model.
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       io_tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .io_tx     (io_tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int k0 = 0;
  int acc = -1;
  int max_cnt = 0;
  logic [7:0] exp_b [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic lvl(input int j);
    int f;
    int p;
    logic [7:0] b;
    f = (j - 1) / FRAME;
    p = (j - 1) % FRAME;
    b = exp_b[f];
    if (p < CPB) return 1'b0;
    if (p < 9 * CPB) return b[(p - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = exp_b[i];
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic watch(input int nf);
    @(posedge clk);
    #1;
    k0 = cyc;
    max_cnt = 0;
    chk("cnt_after_push", 32'(fifo_count), 32'd1);
    chk("busy_after_push", 32'(busy), 32'd1);
    for (int j = 1; j <= nf * FRAME; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("line j=%0d", j), 32'(io_tx), 32'(lvl(j)));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (j == nf * FRAME) chk("busy_last", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("cnt_end", 32'(fifo_count), 32'd0);
    chk("io_end", 32'(io_tx), 32'd1);
  endtask

  task automatic quiet(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!io_tx || busy) bad = 1'b1;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io", 32'(io_tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    reset_n  = 1'b1;
    quiet(5, "idle_after_rst");

    exp_b[0] = 8'hA5;
    @(negedge clk);
    fork
      drive(1);
      watch(1);
    join

    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    @(negedge clk);
    fork
      drive(2);
      watch(2);
    join

    for (int i = 0; i < 6; i++) exp_b[i] = 8'h11 + 8'(i);
    @(negedge clk);
    fork
      drive(6);
      watch(5);
      begin
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("full_cnt", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_cnt", 32'(fifo_count), 32'd4);
      end
    join
    chk("full_max", 32'(max_cnt), 32'd4);
    quiet(150, "no_sixth_frame");

    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_valid = 1'b1;
          tx_data  = exp_b[i];
          @(negedge clk);
        end
        tx_data = 8'h16;
        acc = -1;
        for (int t = 0; t < 300; t++) begin
          if (tx_ready) begin
            acc = cyc + 1;
            @(negedge clk);
            break;
          end
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
      watch(6);
    join
    chk("accept_edge", 32'(acc - k0), 32'd102);
    chk("hold_max", 32'(max_cnt), 32'd4);

    exp_b[0] = 8'h3C;
    exp_b[1] = 8'hA1;
    exp_b[2] = 8'hB2;
    @(negedge clk);
    fork
      drive(3);
      begin
        @(posedge clk);
        repeat (44) @(posedge clk);
        #1;
        chk("mid_cnt", 32'(fifo_count), 32'd2);
        chk("mid_bit3", 32'(io_tx), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk);
        #1;
        chk("mrst_io", 32'(io_tx), 32'd1);
        chk("mrst_cnt", 32'(fifo_count), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mrst_push_ign", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        tx_valid = 1'b0;
      end
    join
    quiet(200, "no_frame_after_rst");

    exp_b[0] = 8'h5A;
    @(negedge clk);
    fork
      drive(1);
      watch(1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
